spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter N, default 8, frame word width in bits.
REQ-002 SHALL have parameter DUMMY, default 8'hFF (N bits), word sent on transmit underrun.
REQ-003 SHALL have port clk_i, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sclk_i, input, 1, SPI clock from master, asynchronous to clk_i.
REQ-006 SHALL have port cs_ni, input, 1, active-low chip select, asynchronous.
REQ-007 SHALL have port mosi_i, input, 1, serial data from master, asynchronous.
REQ-008 SHALL have port miso_o, output, 1, serial data to master.
REQ-009 SHALL have ports tx_data_i (input, N), tx_valid_i (input, 1) and tx_ready_o (output, 1), the transmit word handshake.
REQ-010 SHALL have ports rx_data_o (output, N), rx_valid_o (output, 1) and rx_ready_i (input, 1), the received word handshake.
REQ-011 SHALL have ports overrun_o and underrun_o (outputs, 1, sticky), plus clr_flags_i (input, 1), a pulse that clears both.
REQ-012 SHALL have port busy_o, output, 1, high while state is not IDLE.

Function
REQ-013 SHALL pass sclk_i, cs_ni and mosi_i through 2-flop synchronizers; edges are detected on the synchronized values; sclk_i period SHALL be at least 8 clk_i cycles.
REQ-014 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample on sclk rising, shift out on sclk falling.
REQ-015 SHALL use FSM states IDLE, LOAD, SHIFT: IDLE->LOAD on synchronized cs_ni falling; LOAD->SHIFT after one cycle; SHIFT->LOAD after the Nth sampled rising edge if cs_ni still low; any state->IDLE on synchronized cs_ni high.
REQ-016 In LOAD, SHALL copy the tx holding register into the tx shift register and mark holding empty; if holding is empty, SHALL load DUMMY and set underrun_o.
REQ-017 SHALL drive miso_o from tx shift register MSB while cs_ni (synchronized) is low, and 0 otherwise.
REQ-018 SHALL assert tx_ready_o when the holding register is empty; a write occurs on tx_valid_i && tx_ready_o.
REQ-019 When a write and LOAD occur in the same cycle, SHALL load the old holding content (or DUMMY if empty) and store the new word in holding.
REQ-020 SHALL use a bit counter of width $clog2(N+1) that resets to 0 in LOAD and increments on each sampled rising edge.
REQ-021 On the Nth sample, SHALL move the rx shift register to rx_data_o and assert rx_valid_o on the next cycle.
REQ-022 SHALL hold rx_valid_o until rx_ready_i is high; rx_valid_o && rx_ready_i clears rx_valid_o.
REQ-023 If a new word completes while rx_valid_o is high and not accepted that cycle, SHALL overwrite rx_data_o, keep rx_valid_o high, and set overrun_o.
REQ-024 If cs_ni rises mid-word, SHALL discard the partial word, raise no rx_valid_o, keep the current rx_data_o, and leave any loaded tx word consumed.
REQ-025 When clr_flags_i and a set event occur in the same cycle, SHALL give the set event priority.

Reset
REQ-026 When rst_i is low, SHALL go to IDLE with miso_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, overrun_o=0, underrun_o=0, busy_o=0, counter and shift registers at 0, holding empty, and synchronizers at cs high/sclk low.
REQ-027 Reset mid-frame SHALL abandon the frame; after release, the block SHALL wait for a fresh cs_ni falling edge.

Structure
REQ-028 SHALL place the state enum typedef (IDLE/LOAD/SHIFT) and the default N and DUMMY constants in shared package spi_pkg.
REQ-029 SHALL implement the synchronizer and edge detector as sub-module spi_sync, instantiated once per asynchronous input.

Verification
REQ-030 Bench SHALL cover: preload tx 8'hA5, master sends 8'h3C (sclk = clk/8) -> miso carries A5 MSB-first, rx_data_o=3C, rx_valid_o=1.
REQ-031 Bench SHALL cover: cs held low for two words, tx 8'h12 then 8'h34, master sends 8'h56, 8'h78 -> miso 12,34; rx 56,78; underrun_o=0.
REQ-032 Bench SHALL cover: no tx preload, master sends 8'h00 -> miso=8'hFF and underrun_o=1; clr_flags_i pulse -> underrun_o=0.
REQ-033 Bench SHALL cover: rx_ready_i held 0 across two words 8'h11, 8'h22 -> rx_data_o=8'h22 and overrun_o=1.
REQ-034 Bench SHALL cover: cs_ni raised after 5 bits -> no rx_valid_o, busy_o=0, and the next full frame of 8'h9A is received correctly.
REQ-035 Bench SHALL cover: rst_i low at bit 3 -> all outputs at reset values, and a subsequent frame of 8'hC3 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI slave.
package spi_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_e;
   localparam int             N_DEF     = 8;
   localparam logic [7:0]     DUMMY_DEF = 8'hFF;
endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with an extra history flop for edge detection.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with tx holding register and rx output register.
module spi_slave
   import spi_pkg::*;
#(
   parameter int           N     = N_DEF,
   parameter logic [N-1:0] DUMMY = N'(DUMMY_DEF)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         sclk_i,
   input  logic         cs_ni,
   input  logic         mosi_i,
   output logic         miso_o,
   input  logic [N-1:0] tx_data_i,
   input  logic         tx_valid_i,
   output logic         tx_ready_o,
   output logic [N-1:0] rx_data_o,
   output logic         rx_valid_o,
   input  logic         rx_ready_i,
   output logic         overrun_o,
   output logic         underrun_o,
   input  logic         clr_flags_i,
   output logic         busy_o
);
   localparam int          CW   = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic cs_s, cs_fall, cs_rise_unused;
   logic sclk_rise, sclk_fall, sclk_s_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
      .clk_i(clk_i), .rst_i(rst_i), .async_i(cs_ni),
      .sync_o(cs_s), .rise_o(cs_rise_unused), .fall_o(cs_fall));
   spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(clk_i), .rst_i(rst_i), .async_i(sclk_i),
      .sync_o(sclk_s_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk_i), .rst_i(rst_i), .async_i(mosi_i),
      .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  tx_sh_q, tx_sh_d;
   logic [N-2:0]  rx_sh_q, rx_sh_d;
   logic [N-1:0]  rx_next;
   logic [N-1:0]  hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic [N-1:0]  rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          ovr_q, ovr_d;
   logic          und_q, und_d;

   assign rx_next = {rx_sh_q, mosi_s};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      ovr_d       = ovr_q;
      und_d       = und_q;

      // Clears come first so a same-cycle set below wins.
      if (clr_flags_i) begin
         ovr_d = 1'b0;
         und_d = 1'b0;
      end
      if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

      case (state_q)
         IDLE: if (cs_fall) state_d = LOAD;
         LOAD: begin
            tx_sh_d     = hold_full_q ? hold_q : DUMMY;
            und_d       = und_d | ~hold_full_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            rx_sh_d     = '0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            if (sclk_rise && !cs_s) begin
               rx_sh_d = rx_next[N-2:0];
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
                  if (rx_valid_q && !rx_ready_i) ovr_d = 1'b1;
                  state_d    = LOAD;
               end
            end else if (sclk_fall && cnt_q != '0) begin
               // The fall preceding a word's first sample leaves the freshly loaded MSB in place.
               tx_sh_d = {tx_sh_q[N-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase

      if (tx_valid_i && !hold_full_q) begin
         hold_d      = tx_data_i;
         hold_full_d = 1'b1;
      end
      if (cs_s) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         ovr_q       <= 1'b0;
         und_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         ovr_q       <= ovr_d;
         und_q       <= und_d;
      end
   end

   assign miso_o     = ~cs_s & tx_sh_q[N-1];
   assign tx_ready_o = ~hold_full_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign overrun_o  = ovr_q;
   assign underrun_o = und_q;
   assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave driving an SPI mode-0 master model against a word-level reference.
module tb_spi_slave;
   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic       miso_o;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0, tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, rx_ready = 1'b0;
   logic       overrun_o, underrun_o, clr_flags = 1'b0, busy_o;

   spi_slave dut (
      .clk_i(clk), .rst_i(rst_i), .sclk_i(sclk), .cs_ni(cs_n), .mosi_i(mosi),
      .miso_o(miso_o), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
      .overrun_o(overrun_o), .underrun_o(underrun_o), .clr_flags_i(clr_flags), .busy_o(busy_o));

   always #5 clk = ~clk;

   int         n_chk = 0, n_fail = 0;
   logic [7:0] txq[$];
   logic [7:0] rx_got[$];
   logic [7:0] exp_rx[$];
   logic [7:0] m_rx_data = '0;
   bit         m_pend = 0, m_ovr = 0, m_und = 0;
   logic [31:0] miso_bits, exp_miso;

   always @(posedge clk)
      if (rst_i && rx_valid_o && rx_ready) rx_got.push_back(rx_data_o);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      txq.delete(); exp_rx.delete(); rx_got.delete();
      m_pend = 0; m_ovr = 0; m_und = 0; m_rx_data = '0;
   endtask

   task automatic push(input logic [7:0] d);
      int t = 0;
      while (!tx_ready_o && t < 400) begin tick(1); t++; end
      n_chk++;
      if (!tx_ready_o) begin
         n_fail++;
         $display("FAIL push_ready: tx_ready_o=%b required 1 within 400 cycles", tx_ready_o);
      end else begin
         tx_data = d; tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
         txq.push_back(d);
      end
   endtask

   task automatic set_ready(input logic b);
      rx_ready = b;
      if (b && m_pend) begin exp_rx.push_back(m_rx_data); m_pend = 0; end
      tick(2);
   endtask

   task automatic cleanup();
      set_ready(1'b1);
      clr_flags = 1'b1; tick(1); clr_flags = 1'b0; tick(1);
      m_ovr = 0; m_und = 0;
      rx_got.delete(); exp_rx.delete();
   endtask

   // Master: bits[nbits-1] goes first; miso is sampled just before each rising edge.
   task automatic xfer(input int nbits, input logic [31:0] bits, input bit keep_cs);
      cs_n = 1'b0; mosi = bits[nbits-1];
      tick(8);
      miso_bits = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = bits[i];
         tick(4);
         miso_bits = {miso_bits[30:0], miso_o};
         sclk = 1'b1; tick(4); sclk = 1'b0;
      end
      tick(8);
      if (!keep_cs) begin cs_n = 1'b1; tick(8); end
   endtask

   // Every completed word is followed by a load, plus the load at frame start.
   task automatic model_frame(input int nbits, input logic [31:0] bits);
      int k;
      logic [7:0] ld[4];
      logic [7:0] w;
      k = nbits / 8;
      for (int l = 0; l <= k; l++) begin
         if (txq.size() > 0) ld[l] = txq.pop_front();
         else begin ld[l] = 8'hFF; m_und = 1; end
      end
      exp_miso = '0;
      for (int j = 0; j < nbits; j++) exp_miso = {exp_miso[30:0], ld[j/8][7-(j%8)]};
      for (int l = 0; l < k; l++) begin
         w = bits[nbits-1-8*l -: 8];
         m_rx_data = w;
         if (rx_ready) exp_rx.push_back(w);
         else begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0; tick(3);
      n_chk++;
      if ({miso_o, tx_ready_o, rx_valid_o, rx_data_o, overrun_o, underrun_o, busy_o} !== 14'b0_1_0_00000000_0_0_0) begin
         n_fail++;
         $display("FAIL reset_outputs: got miso=%b rdy=%b rxv=%b rxd=%h ovr=%b und=%b busy=%b required 0 1 0 00 0 0 0",
                  miso_o, tx_ready_o, rx_valid_o, rx_data_o, overrun_o, underrun_o, busy_o);
      end
      rst_i = 1'b1; tick(3);
      model_reset();
   endtask

   task automatic test_basic();
      push(8'hA5);
      xfer(8, 32'h3C, 0);
      model_frame(8, 32'h3C);
      n_chk++;
      if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL basic_miso: got %h required %h", miso_bits, exp_miso); end
      n_chk++;
      if (rx_data_o !== 8'h3C || rx_data_o !== m_rx_data) begin n_fail++; $display("FAIL basic_rx_data: got %h required 3c", rx_data_o); end
      n_chk++;
      if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_rx_valid: got %b required 1", rx_valid_o); end
      n_chk++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0", busy_o); end
      cleanup();
   endtask

   task automatic test_back_to_back();
      logic [7:0] filler;
      filler = 8'($urandom);
      set_ready(1'b1);
      push(8'h12);
      fork
         xfer(16, 32'h5678, 0);
         begin push(8'h34); push(filler); end
      join
      model_frame(16, 32'h5678);
      n_chk++;
      if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL b2b_miso: got %h required %h", miso_bits, exp_miso); end
      n_chk++;
      if (rx_got.size() != exp_rx.size()) begin
         n_fail++; $display("FAIL b2b_rx_count: got %0d words required %0d", rx_got.size(), exp_rx.size());
      end else
         for (int i = 0; i < exp_rx.size(); i++) begin
            n_chk++;
            if (rx_got[i] !== exp_rx[i]) begin n_fail++; $display("FAIL b2b_rx_word%0d: got %h required %h", i, rx_got[i], exp_rx[i]); end
         end
      n_chk++;
      if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun: got %b required 0", underrun_o); end
      cleanup();
   endtask

   task automatic test_underrun();
      set_ready(1'b0);
      xfer(8, 32'h00, 0);
      model_frame(8, 32'h00);
      n_chk++;
      if (miso_bits[7:0] !== 8'hFF) begin n_fail++; $display("FAIL underrun_miso: got %h required ff", miso_bits[7:0]); end
      n_chk++;
      if (underrun_o !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b required 1", underrun_o); end
      clr_flags = 1'b1; tick(1); clr_flags = 1'b0; tick(1);
      m_und = 0; m_ovr = 0;
      n_chk++;
      if (underrun_o !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: got %b required 0", underrun_o); end
      cleanup();
   endtask

   task automatic test_overrun();
      set_ready(1'b0);
      push(8'($urandom));
      xfer(16, 32'h1122, 0);
      model_frame(16, 32'h1122);
      n_chk++;
      if (rx_data_o !== 8'h22) begin n_fail++; $display("FAIL overrun_data: got %h required 22", rx_data_o); end
      n_chk++;
      if (rx_valid_o !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b required 1", rx_valid_o); end
      n_chk++;
      if (overrun_o !== m_ovr || m_ovr != 1) begin n_fail++; $display("FAIL overrun_flag: got %b required 1", overrun_o); end
      cleanup();
   endtask

   task automatic test_abort();
      set_ready(1'b0);
      push(8'($urandom));
      xfer(5, 32'h13, 0);
      model_frame(5, 32'h13);
      n_chk++;
      if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL abort_miso: got %h required %h", miso_bits, exp_miso); end
      n_chk++;
      if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_rx_valid: got %b required 0", rx_valid_o); end
      n_chk++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy_o); end
      n_chk++;
      if (tx_ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_tx_consumed: got %b required 1", tx_ready_o); end
      push(8'($urandom));
      xfer(8, 32'h9A, 0);
      model_frame(8, 32'h9A);
      n_chk++;
      if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL abort_next_miso: got %h required %h", miso_bits, exp_miso); end
      n_chk++;
      if (rx_data_o !== 8'h9A || rx_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL abort_next_rx: got %h/%b required 9a/1", rx_data_o, rx_valid_o);
      end
      cleanup();
   endtask

   task automatic test_reset_mid();
      set_ready(1'b0);
      push(8'($urandom));
      xfer(3, 32'h5, 1);
      rst_i = 1'b0; tick(2);
      n_chk++;
      if ({miso_o, tx_ready_o, rx_valid_o, rx_data_o, overrun_o, underrun_o, busy_o} !== 14'b0_1_0_00000000_0_0_0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got miso=%b rdy=%b rxv=%b rxd=%h ovr=%b und=%b busy=%b required 0 1 0 00 0 0 0",
                  miso_o, tx_ready_o, rx_valid_o, rx_data_o, overrun_o, underrun_o, busy_o);
      end
      cs_n = 1'b1; sclk = 1'b0; tick(2);
      rst_i = 1'b1; tick(4);
      model_reset();
      push(8'($urandom));
      xfer(8, 32'hC3, 0);
      model_frame(8, 32'hC3);
      n_chk++;
      if (rx_data_o !== 8'hC3 || rx_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL midreset_rx: got %h/%b required c3/1", rx_data_o, rx_valid_o);
      end
      n_chk++;
      if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL midreset_miso: got %h required %h", miso_bits, exp_miso); end
      cleanup();
   endtask

   task automatic test_random();
      int         nw;
      logic [31:0] bits;
      for (int f = 0; f < 8; f++) begin
         set_ready(1'($urandom));
         if ($urandom_range(0, 2) != 0) push(8'($urandom));
         nw   = $urandom_range(1, 3);
         bits = $urandom & ((32'h1 << (8 * nw)) - 1);
         xfer(8 * nw, bits, 0);
         model_frame(8 * nw, bits);
         n_chk++;
         if (miso_bits !== exp_miso) begin n_fail++; $display("FAIL rand%0d_miso: got %h required %h", f, miso_bits, exp_miso); end
         n_chk++;
         if (rx_data_o !== m_rx_data) begin n_fail++; $display("FAIL rand%0d_rx_data: got %h required %h", f, rx_data_o, m_rx_data); end
         n_chk++;
         if (rx_valid_o !== m_pend) begin n_fail++; $display("FAIL rand%0d_rx_valid: got %b required %b", f, rx_valid_o, m_pend); end
         n_chk++;
         if ({overrun_o, underrun_o} !== {m_ovr, m_und}) begin
            n_fail++; $display("FAIL rand%0d_flags: got ovr=%b und=%b required %b %b", f, overrun_o, underrun_o, m_ovr, m_und);
         end
         n_chk++;
         if (rx_got.size() != exp_rx.size()) begin
            n_fail++; $display("FAIL rand%0d_rx_count: got %0d required %0d", f, rx_got.size(), exp_rx.size());
         end else
            for (int i = 0; i < exp_rx.size(); i++) begin
               n_chk++;
               if (rx_got[i] !== exp_rx[i]) begin n_fail++; $display("FAIL rand%0d_rx_word%0d: got %h required %h", f, i, rx_got[i], exp_rx[i]); end
            end
         rx_got.delete(); exp_rx.delete();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_underrun();
      test_overrun();
      test_abort();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
